// File: rtl/sys1_input_ctrl.sv
// sys1_input_ctrl: maps PS/2 keys and two joysticks onto the
// active-low INP0/INP1/INP2 ports, with a framed coin pulser.
// Ports:
//   clk_sys, reset_n      clock, synchronous active-low reset
//   ps2_key[10:0]         [10] event toggle, [9] pressed, [8:0] code
//   joy1, joy2[15:0]      active-high joysticks (bit 8 = coin)
//   vblank                vertical blank, frames the coin pulse
//   cabinet               1 = cocktail, 0 = upright (P2 merged)
//   INP0/INP1/INP2[7:0]   registered active-low game inputs
module sys1_input_ctrl #(
  parameter int COIN_FRAMES     = 3,
  parameter int COIN_GAP_FRAMES = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        vblank,
  input  logic        cabinet,
  output logic [7:0]  INP0,
  output logic [7:0]  INP1,
  output logic [7:0]  INP2
);

  localparam int CMAX =
    (COIN_FRAMES > COIN_GAP_FRAMES) ?
    COIN_FRAMES : COIN_GAP_FRAMES;
  localparam int CW  = (CMAX < 1) ? 1 : $clog2(CMAX + 1);
  localparam int CW1 = CW + 1;

  localparam logic [CW:0] PULSE_END = CW1'(COIN_FRAMES);
  localparam logic [CW:0] GAP_END   = CW1'(COIN_GAP_FRAMES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic ps2_q, vb_q, creq_q;

  logic k_up1, k_down1, k_left1, k_right1;
  logic k_trig1, k_trig2;
  logic k_f1, k_f2, k_start1, k_start2;
  logic k_coin1, k_coin2;
  logic k_up2, k_down2, k_left2, k_right2;
  logic k_p2trig1, k_p2trig2;

  logic up2, down2, left2, right2, trig1_2, trig2_2;
  logic up1, down1, left1, right1, trig1_1, trig2_1;
  logic start1, start2, creq;

  logic key_evt, vb_edge, creq_edge;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW:0]   cnt_inc;
  logic          pending, pending_nxt;
  logic          coin_out;

  logic unused_ok;
  assign unused_ok = ^{joy1[15:9], joy2[15:9]};

  assign key_evt   = ps2_key[10] ^ ps2_q;
  assign vb_edge   = vblank & ~vb_q;
  assign creq_edge = creq & ~creq_q;

  // Player 2 first: upright cabinets fold it into player 1
  assign up2     = k_up2     | joy2[3];
  assign down2   = k_down2   | joy2[2];
  assign left2   = k_left2   | joy2[1];
  assign right2  = k_right2  | joy2[0];
  assign trig1_2 = k_p2trig1 | joy2[4];
  assign trig2_2 = k_p2trig2 | joy2[5];

  assign up1     = k_up1    | joy1[3] | (~cabinet & up2);
  assign down1   = k_down1  | joy1[2] | (~cabinet & down2);
  assign left1   = k_left1  | joy1[1] | (~cabinet & left2);
  assign right1  = k_right1 | joy1[0] | (~cabinet & right2);
  assign trig1_1 = k_trig1  | joy1[4] | (~cabinet & trig1_2);
  assign trig2_1 = k_trig2  | joy1[5] | (~cabinet & trig2_2);

  assign start1 = k_f1 | k_start1 | joy1[6] | joy2[6];
  assign start2 = k_f2 | k_start2 | joy1[7] | joy2[7];

  assign creq = k_f1 | k_f2 | k_coin1 | k_coin2
              | joy1[8] | joy2[8];

  // History registers track inputs even in reset so that
  // nothing fires on the first clock after release.
  always_ff @(posedge clk_sys) begin
    ps2_q  <= ps2_key[10];
    vb_q   <= vblank;
    creq_q <= creq;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      k_up1     <= 1'b0;
      k_down1   <= 1'b0;
      k_left1   <= 1'b0;
      k_right1  <= 1'b0;
      k_trig1   <= 1'b0;
      k_trig2   <= 1'b0;
      k_f1      <= 1'b0;
      k_f2      <= 1'b0;
      k_start1  <= 1'b0;
      k_start2  <= 1'b0;
      k_coin1   <= 1'b0;
      k_coin2   <= 1'b0;
      k_up2     <= 1'b0;
      k_down2   <= 1'b0;
      k_left2   <= 1'b0;
      k_right2  <= 1'b0;
      k_p2trig1 <= 1'b0;
      k_p2trig2 <= 1'b0;
    end else if (key_evt) begin
      case (ps2_key[8:0])
        9'h075, 9'h175: k_up1    <= ps2_key[9];
        9'h072, 9'h172: k_down1  <= ps2_key[9];
        9'h06B, 9'h16B: k_left1  <= ps2_key[9];
        9'h074, 9'h174: k_right1 <= ps2_key[9];
        9'h029: k_trig1   <= ps2_key[9];
        9'h014: k_trig2   <= ps2_key[9];
        9'h005: k_f1      <= ps2_key[9];
        9'h006: k_f2      <= ps2_key[9];
        9'h016: k_start1  <= ps2_key[9];
        9'h01E: k_start2  <= ps2_key[9];
        9'h02E: k_coin1   <= ps2_key[9];
        9'h036: k_coin2   <= ps2_key[9];
        9'h02D: k_up2     <= ps2_key[9];
        9'h02B: k_down2   <= ps2_key[9];
        9'h023: k_left2   <= ps2_key[9];
        9'h034: k_right2  <= ps2_key[9];
        9'h01C: k_p2trig1 <= ps2_key[9];
        9'h01B: k_p2trig2 <= ps2_key[9];
        default: ;
      endcase
    end
  end

  // Coin FSM: state register
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
    end
  end

  assign cnt_inc = {1'b0, cnt} + CW1'(1);

  // Coin FSM: next state. Terminal counts are compared on the
  // incremented value so a zero parameter exits on the first edge.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pending_nxt = pending;
    unique case (state)
      IDLE: begin
        if (creq_edge) begin
          state_nxt = PULSE;
          cnt_nxt   = '0;
        end
      end
      PULSE: begin
        if (creq_edge)
          pending_nxt = 1'b1;
        if (vb_edge) begin
          if (cnt_inc >= PULSE_END) begin
            state_nxt = GAP;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc[CW-1:0];
          end
        end
      end
      GAP: begin
        if (creq_edge)
          pending_nxt = 1'b1;
        if (vb_edge) begin
          if (cnt_inc >= GAP_END) begin
            cnt_nxt = '0;
            if (pending_nxt) begin
              state_nxt   = PULSE;
              pending_nxt = 1'b0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = cnt_inc[CW-1:0];
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        cnt_nxt     = '0;
        pending_nxt = 1'b0;
      end
    endcase
  end

  // Coin FSM: outputs
  always_comb begin
    coin_out = 1'b0;
    if (state == PULSE)
      coin_out = 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      INP0 <= 8'hFF;
      INP1 <= 8'hFF;
      INP2 <= 8'hFF;
    end else begin
      INP0 <= ~{left1, right1, up1, down1,
                1'b0, trig2_1, trig1_1, 1'b0};
      INP1 <= ~{left2, right2, up2, down2,
                1'b0, trig2_2, trig1_2, 1'b0};
      INP2 <= ~{2'b00, start2, start1,
                3'b000, coin_out};
    end
  end

endmodule

// File: tb/tb_sys1_input_ctrl.sv
// tb_sys1_input_ctrl: directed vectors and coin sequences
// for sys1_input_ctrl with default frame parameters.
module tb_sys1_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy1    = '0;
  logic [15:0] joy2    = '0;
  logic        vblank  = 1'b0;
  logic        cabinet = 1'b0;
  logic [7:0]  INP0, INP1, INP2;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] j1;
    logic [15:0] j2;
    logic        cab;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  e2;
  } vec_t;

  vec_t vecs[13];

  always #5 clk_sys = ~clk_sys;

  sys1_input_ctrl dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ps2_key (ps2_key),
    .joy1    (joy1),
    .joy2    (joy2),
    .vblank  (vblank),
    .cabinet (cabinet),
    .INP0    (INP0),
    .INP1    (INP1),
    .INP2    (INP2)
  );

  function automatic void chk(string name,
                              logic [7:0] act,
                              logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic key(logic pr, logic [8:0] code);
    ps2_key = {~ps2_key[10], pr, code};
  endtask

  task automatic vpulse();
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    tick();
  endtask

  initial begin
    int falls;
    logic prev;
    logic [7:0] exp2;

    vecs[0]  = '{16'h0000, 16'h0000, 1'b0, 8'hFF, 8'hFF, 8'hFF};
    vecs[1]  = '{16'h0001, 16'h0000, 1'b0, 8'hBF, 8'hFF, 8'hFF};
    vecs[2]  = '{16'h0002, 16'h0000, 1'b0, 8'h7F, 8'hFF, 8'hFF};
    vecs[3]  = '{16'h0004, 16'h0000, 1'b0, 8'hEF, 8'hFF, 8'hFF};
    vecs[4]  = '{16'h0008, 16'h0000, 1'b0, 8'hDF, 8'hFF, 8'hFF};
    vecs[5]  = '{16'h0010, 16'h0000, 1'b0, 8'hFD, 8'hFF, 8'hFF};
    vecs[6]  = '{16'h0020, 16'h0000, 1'b0, 8'hFB, 8'hFF, 8'hFF};
    vecs[7]  = '{16'h0040, 16'h0000, 1'b0, 8'hFF, 8'hFF, 8'hEF};
    vecs[8]  = '{16'h0000, 16'h0080, 1'b0, 8'hFF, 8'hFF, 8'hDF};
    vecs[9]  = '{16'h0000, 16'h0008, 1'b0, 8'hDF, 8'hDF, 8'hFF};
    vecs[10] = '{16'h0000, 16'h0008, 1'b1, 8'hFF, 8'hDF, 8'hFF};
    vecs[11] = '{16'h0003, 16'h0030, 1'b1, 8'h3F, 8'hF9, 8'hFF};
    vecs[12] = '{16'hFE00, 16'hFE00, 1'b0, 8'hFF, 8'hFF, 8'hFF};

    // reset state
    tick(3);
    chk("rst_inp0", INP0, 8'hFF);
    chk("rst_inp1", INP1, 8'hFF);
    chk("rst_inp2", INP2, 8'hFF);
    reset_n = 1'b1;
    tick();
    chk("post_rst_inp2", INP2, 8'hFF);

    // joystick vectors, one-clock latency
    for (int i = 0; i < 13; i++) begin
      joy1    = vecs[i].j1;
      joy2    = vecs[i].j2;
      cabinet = vecs[i].cab;
      tick();
      chk($sformatf("vec%0d_inp0", i), INP0, vecs[i].e0);
      chk($sformatf("vec%0d_inp1", i), INP1, vecs[i].e1);
      chk($sformatf("vec%0d_inp2", i), INP2, vecs[i].e2);
    end
    joy1 = '0;
    joy2 = '0;
    cabinet = 1'b0;
    tick();

    // key event: two-clock latency
    key(1'b1, 9'h075);
    tick();
    chk("key_up_lat1", INP0, 8'hFF);
    tick();
    chk("key_up_press", INP0, 8'hDF);
    key(1'b0, 9'h075);
    tick(2);
    chk("key_up_release", INP0, 8'hFF);
    key(1'b1, 9'h175);
    tick(2);
    chk("key_ext_up", INP0, 8'hDF);
    key(1'b0, 9'h175);
    tick(2);
    chk("key_ext_up_rel", INP0, 8'hFF);
    key(1'b1, 9'h042);
    tick(2);
    chk("key_unknown", INP0, 8'hFF);
    key(1'b1, 9'h129);
    tick(2);
    chk("key_ext_trig", INP0, 8'hFF);

    // P2 key merge vs cocktail
    key(1'b1, 9'h02D);
    tick(2);
    chk("p2key_upr_inp0", INP0, 8'hDF);
    chk("p2key_upr_inp1", INP1, 8'hDF);
    cabinet = 1'b1;
    tick();
    chk("p2key_cab_inp0", INP0, 8'hFF);
    chk("p2key_cab_inp1", INP1, 8'hDF);
    key(1'b0, 9'h02D);
    tick(2);
    chk("p2key_rel_inp1", INP1, 8'hFF);
    cabinet = 1'b0;
    tick();

    // single coin pulse framed by vblank
    joy1[8] = 1'b1;
    tick();
    joy1[8] = 1'b0;
    tick();
    chk("coin1_start", INP2, 8'hFE);
    for (int k = 1; k <= 6; k++) begin
      vpulse();
      exp2 = (k <= 2) ? 8'hFE : 8'hFF;
      chk($sformatf("coin1_edge%0d", k), INP2, exp2);
    end

    // three requests during a pulse -> two pulses
    joy2[8] = 1'b1;
    tick();
    joy2[8] = 1'b0;
    tick();
    chk("coin2_start", INP2, 8'hFE);
    for (int r = 0; r < 2; r++) begin
      joy2[8] = 1'b1;
      tick();
      joy2[8] = 1'b0;
      tick();
    end
    falls = 0;
    prev  = INP2[0];
    for (int k = 1; k <= 14; k++) begin
      vpulse();
      exp2 = ((k <= 2) || (k >= 6 && k <= 8)) ?
             8'hFE : 8'hFF;
      chk($sformatf("coin2_edge%0d", k), INP2, exp2);
      if (prev && !INP2[0])
        falls++;
      prev = INP2[0];
    end
    chk("coin2_extra_pulses", 8'(falls), 8'd1);

    // F1: start + coin, held key gives only one pulse
    key(1'b1, 9'h005);
    tick(2);
    chk("f1_start_only", INP2, 8'hEF);
    tick();
    chk("f1_start_coin", INP2, 8'hEE);
    for (int k = 1; k <= 9; k++) begin
      vpulse();
      exp2 = (k <= 2) ? 8'hEE : 8'hEF;
      chk($sformatf("f1_edge%0d", k), INP2, exp2);
    end
    key(1'b0, 9'h005);
    tick(2);
    chk("f1_release", INP2, 8'hFF);

    // reset in the middle of a pulse with pending request
    key(1'b1, 9'h075);
    tick(2);
    chk("mid_key_up", INP0, 8'hDF);
    for (int r = 0; r < 2; r++) begin
      joy1[8] = 1'b1;
      tick();
      joy1[8] = 1'b0;
      tick();
    end
    vpulse();
    chk("mid_pulse", INP2, 8'hFE);
    reset_n = 1'b0;
    key(1'b1, 9'h072);
    tick();
    chk("mid_rst_inp0", INP0, 8'hFF);
    chk("mid_rst_inp1", INP1, 8'hFF);
    chk("mid_rst_inp2", INP2, 8'hFF);
    reset_n = 1'b1;
    tick(2);
    chk("mid_rel_inp0", INP0, 8'hFF);
    chk("mid_rel_inp2", INP2, 8'hFF);
    for (int k = 1; k <= 8; k++) begin
      vpulse();
      chk($sformatf("mid_rel_edge%0d", k), INP2, 8'hFF);
    end
    chk("mid_rel_final_inp0", INP0, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
